// File: rtl/uart_frame_rx.sv
// uart_frame_rx: assembles fixed-length frames from a byte stream, checks
// length and XOR checksum, and publishes accepted payloads with a valid pulse.
module uart_frame_rx #(
    parameter int unsigned BUFFER_SIZE  = 64,
    parameter int unsigned USE_CHECKSUM = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_data_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_endofpacket,
    output logic [BUFFER_SIZE-1:0] frame_data,
    output logic                   frame_valid,
    output logic                   frame_error,
    output logic [7:0]             err_count,
    output logic                   busy
);

    localparam int unsigned N  = BUFFER_SIZE / 8;
    localparam int unsigned L  = N + USE_CHECKSUM;
    localparam int unsigned CW = $clog2(L + 1);

    localparam logic [CW-1:0] N_C = CW'(N);
    localparam logic [CW-1:0] L_C = CW'(L);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE,
        DROP
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
    logic [BUFFER_SIZE-1:0] shreg, shreg_nxt;
    logic [7:0]             xor_acc, xor_nxt;
    logic [7:0]             chk, chk_nxt;
    logic                   accept, reject;

    // Next-state logic: the byte (if any) is applied first, then end-of-packet
    // is judged against the resulting post-byte state within the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        xor_nxt   = xor_acc;
        chk_nxt   = chk;
        accept    = 1'b0;
        reject    = 1'b0;
        cnt_inc   = cnt + 1'b1;

        if (rx_data_ready) begin
            case (state)
                IDLE: begin
                    shreg_nxt = (shreg << 8) | BUFFER_SIZE'(rx_data);
                    cnt_nxt   = CW'(1);
                    xor_nxt   = rx_data;
                    state_nxt = (L == 1) ? DONE : RECV;
                end
                RECV: begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc <= N_C) begin
                        shreg_nxt = (shreg << 8) | BUFFER_SIZE'(rx_data);
                        xor_nxt   = xor_acc ^ rx_data;
                    end else begin
                        chk_nxt = rx_data;
                    end
                    if (cnt_inc == L_C) state_nxt = DONE;
                end
                DONE:    state_nxt = DROP;
                default: ;
            endcase
        end

        if (rx_endofpacket) begin
            case (state_nxt)
                RECV, DROP: begin
                    reject    = 1'b1;
                    state_nxt = IDLE;
                end
                DONE: begin
                    if (USE_CHECKSUM == 0 || chk_nxt == xor_nxt) accept = 1'b1;
                    else                                         reject = 1'b1;
                    state_nxt = IDLE;
                end
                default: ;
            endcase
        end

        if (state_nxt == IDLE) begin
            cnt_nxt = '0;
            xor_nxt = '0;
        end
    end

    // Frame assembly state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            xor_acc <= '0;
            chk     <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            xor_acc <= xor_nxt;
            chk     <= chk_nxt;
        end
    end

    // Published results: one strobe per packet, saturating reject counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_valid <= accept;
            frame_error <= reject;
            if (accept) frame_data <= shreg_nxt;
            if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: table of packets on a 32-bit/checksum
// instance plus hand sequences for reset, saturation and the 8-bit no-checksum case.
module tb_uart_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_rdy = 1'b0, a_eop = 1'b0;
    logic [7:0]  a_data = '0;
    logic [31:0] a_fdata;
    logic        a_fvalid, a_ferr, a_busy;
    logic [7:0]  a_errs;

    logic        b_rdy = 1'b0, b_eop = 1'b0;
    logic [7:0]  b_data = '0;
    logic [7:0]  b_fdata;
    logic        b_fvalid, b_ferr, b_busy;
    logic [7:0]  b_errs;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    uart_frame_rx #(.BUFFER_SIZE(32), .USE_CHECKSUM(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rx_data_ready(a_rdy), .rx_data(a_data), .rx_endofpacket(a_eop),
        .frame_data(a_fdata), .frame_valid(a_fvalid), .frame_error(a_ferr),
        .err_count(a_errs), .busy(a_busy)
    );

    uart_frame_rx #(.BUFFER_SIZE(8), .USE_CHECKSUM(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rx_data_ready(b_rdy), .rx_data(b_data), .rx_endofpacket(b_eop),
        .frame_data(b_fdata), .frame_valid(b_fvalid), .frame_error(b_ferr),
        .err_count(b_errs), .busy(b_busy)
    );

    typedef struct {
        int unsigned len;
        logic [63:0] bytes;      // first byte in [63:56]
        bit          eop_with_last;
        bit          exp_valid;
        bit          exp_error;
        logic [31:0] exp_data;
        logic [7:0]  exp_errs;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus on instance A (sel=0) or B (sel=1); sampled #1 after the edge.
    task automatic drive(input bit sel, input bit rdy, input logic [7:0] d, input bit eop);
        if (sel) begin b_rdy = rdy; b_data = d; b_eop = eop; end
        else     begin a_rdy = rdy; a_data = d; a_eop = eop; end
        @(posedge clk);
        #1;
        a_rdy = 1'b0; a_eop = 1'b0; a_data = '0;
        b_rdy = 1'b0; b_eop = 1'b0; b_data = '0;
    endtask

    task automatic run_pkt(input vec_t v, input string tag);
        for (int i = 0; i < int'(v.len); i++) begin
            bit last;
            last = (i == int'(v.len) - 1);
            drive(1'b0, 1'b1, v.bytes[63-8*i -: 8], last && v.eop_with_last);
            if (!(last && v.eop_with_last)) begin
                check({tag, " no strobe mid-packet"}, {62'd0, a_fvalid, a_ferr}, 64'd0);
                check({tag, " busy mid-packet"}, {63'd0, a_busy}, 64'd1);
            end
        end
        if (!(v.len != 0 && v.eop_with_last)) drive(1'b0, 1'b0, 8'h00, 1'b1);
        check({tag, " frame_valid"}, {63'd0, a_fvalid}, {63'd0, v.exp_valid});
        check({tag, " frame_error"}, {63'd0, a_ferr}, {63'd0, v.exp_error});
        check({tag, " frame_data"}, {32'd0, a_fdata}, {32'd0, v.exp_data});
        check({tag, " err_count"}, {56'd0, a_errs}, {56'd0, v.exp_errs});
        check({tag, " busy after eop"}, {63'd0, a_busy}, 64'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check({tag, " strobes one cycle"}, {62'd0, a_fvalid, a_ferr}, 64'd0);
    endtask

    initial begin
        vec_t good;
        //           len  bytes                    eopw valid err data          errs
        vecs[0] = '{5, 64'h11223344_44000000, 1'b0, 1'b1, 1'b0, 32'h11223344, 8'd0};
        vecs[1] = '{5, 64'h11223344_45000000, 1'b0, 1'b0, 1'b1, 32'h11223344, 8'd1};
        vecs[2] = '{3, 64'hAABBCC00_00000000, 1'b0, 1'b0, 1'b1, 32'h11223344, 8'd2};
        vecs[3] = '{6, 64'h01020304_05060000, 1'b0, 1'b0, 1'b1, 32'h11223344, 8'd3};
        vecs[4] = '{5, 64'h0A0B0C0D_00000000, 1'b1, 1'b1, 1'b0, 32'h0A0B0C0D, 8'd3};
        vecs[5] = '{0, 64'h0,                 1'b0, 1'b0, 1'b0, 32'h0A0B0C0D, 8'd3};
        vecs[6] = '{5, 64'hDEADBEEF_22000000, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 8'd3};
        vecs[7] = '{4, 64'h11223344_00000000, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'd4};
        vecs[8] = '{6, 64'h01020304_04770000, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'd5};
        vecs[9] = '{5, 64'h01020304_05000000, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'd6};

        repeat (2) @(posedge clk);
        #1;
        check("reset frame_data", {32'd0, a_fdata}, 64'd0);
        check("reset strobes/busy", {61'd0, a_fvalid, a_ferr, a_busy}, 64'd0);
        check("reset err_count", {56'd0, a_errs}, 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) run_pkt(vecs[k], $sformatf("vec%0d", k));

        // Reset in the middle of a packet discards it and clears all outputs.
        drive(1'b0, 1'b1, 8'h01, 1'b0);
        drive(1'b0, 1'b1, 8'h02, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midreset frame_data", {32'd0, a_fdata}, 64'd0);
        check("midreset err_count", {56'd0, a_errs}, 64'd0);
        check("midreset strobes/busy", {61'd0, a_fvalid, a_ferr, a_busy}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        good = '{5, 64'h01020304_04000000, 1'b0, 1'b1, 1'b0, 32'h01020304, 8'd0};
        run_pkt(good, "postreset");

        // Saturation of the reject counter.
        for (int p = 0; p < 300; p++) begin
            for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h11 * (i + 1), 1'b0);
            drive(1'b0, 1'b1, 8'h45, 1'b1);
            if (p == 254) check("errs at 255th", {56'd0, a_errs}, 64'd255);
            if (p == 299) check("sat error pulse", {63'd0, a_ferr}, 64'd1);
        end
        check("sat err_count holds", {56'd0, a_errs}, 64'd255);
        check("sat frame_data kept", {32'd0, a_fdata}, 64'h01020304);
        good = '{5, 64'hDEADBEEF_22000000, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 8'd255};
        run_pkt(good, "aftersat");

        // 8-bit, no checksum instance.
        drive(1'b1, 1'b1, 8'h5A, 1'b1);
        check("b same-cycle valid", {61'd0, b_fvalid, b_ferr, b_busy}, 64'b100);
        check("b same-cycle data", {56'd0, b_fdata}, 64'h5A);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("b valid one cycle", {63'd0, b_fvalid}, 64'd0);
        drive(1'b1, 1'b1, 8'hC3, 1'b0);
        check("b busy in DONE", {63'd0, b_busy}, 64'd1);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        check("b late eop valid", {62'd0, b_fvalid, b_ferr}, 64'b10);
        check("b late eop data", {56'd0, b_fdata}, 64'hC3);
        drive(1'b1, 1'b1, 8'h77, 1'b0);
        drive(1'b1, 1'b1, 8'h88, 1'b0);
        check("b overlong no strobe", {62'd0, b_fvalid, b_ferr}, 64'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        check("b overlong error", {62'd0, b_fvalid, b_ferr}, 64'b01);
        check("b overlong data kept", {56'd0, b_fdata}, 64'hC3);
        check("b err_count", {56'd0, b_errs}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
